// File: rtl/neuron_pkg.sv
// neuron_pkg: Q8.24 constants, FSM state type and sign-extension helper shared by the neuron datapath
package neuron_pkg;
    localparam int          FRAC_BITS = 24;
    localparam logic [31:0] Q_ONE     = 32'h0100_0000;
    localparam logic [31:0] Q_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN     = 32'h8000_0000;

    typedef enum logic {ACC, OUT} state_t;

    function automatic logic [63:0] sign_ext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction
endpackage

// File: rtl/fixed_mul_q824.sv
// fixed_mul_q824: combinational signed Q8.24 multiply, full 64-bit product floored right by FRAC_BITS
//   a, b : signed 32-bit operands
//   p    : 64-bit product arithmetic-shifted right by FRAC_BITS (no rounding)
module fixed_mul_q824
    import neuron_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic signed [63:0] full;

    assign full = $signed(sign_ext(a)) * $signed(sign_ext(b));
    assign p    = full >>> FRAC_BITS;
endmodule

// File: rtl/neuron_weighted_sum.sv
// neuron_weighted_sum: sequential MAC producing z = bias + sum(x*w) in Q8.24 for the tanh stage
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input pair handshake (in_ready decoded from state only)
//   x, w                 : signed Q8.24 activation and weight
//   bias                 : signed Q8.24 bias, used on the first beat of a group only
//   out_valid / out_ready: result handshake
//   z_value              : signed Q8.24 pre-activation result
//   sat_flag             : result was clamped (only when NEURON_WEIGHTED_SUM_SAT_EN is defined)
// Macro NEURON_WEIGHTED_SUM_SAT_EN selects saturating output formatting instead of wrap.
module neuron_weighted_sum
    import neuron_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int FRAC_BITS = 24,
    parameter int ACC_W     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] w,
    input  logic [31:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef NEURON_WEIGHTED_SUM_SAT_EN
    output logic        sat_flag,
`endif
    output logic [31:0] z_value
);
    state_t state, state_next;
    logic [15:0]             cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [63:0]             p;
    logic                    beat;
    logic                    last;
    logic                    fits;
    logic [31:0]             fmt;

    fixed_mul_q824 u_mul (.a(x), .b(w), .p(p));

    assign in_ready  = state == ACC;
    assign out_valid = state == OUT;
    assign beat      = in_valid && in_ready;
    assign last      = cnt == 16'(N_INPUTS - 1);
    assign sum       = (cnt == 16'd0 ? ACC_W'($signed(sign_ext(bias))) : acc) + ACC_W'($signed(p));
    // The sum fits in 32 bits when every bit above bit 31 matches the sign bit.
    assign fits      = sum[ACC_W-1:31] == {(ACC_W-31){sum[31]}};

`ifdef NEURON_WEIGHTED_SUM_SAT_EN
    assign fmt = fits ? sum[31:0] : (sum[ACC_W-1] ? Q_MIN : Q_MAX);
`else
    assign fmt = sum[31:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACC;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ACC)
            state_next = (beat && last) ? OUT : ACC;
        else
            state_next = out_ready ? ACC : OUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            z_value <= '0;
        end else if (beat) begin
            acc <= sum;
            cnt <= last ? 16'd0 : cnt + 16'd1;
            if (last)
                z_value <= fmt;
        end
    end

`ifdef NEURON_WEIGHTED_SUM_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (beat && last)
            sat_flag <= !fits;
        else if (state == OUT && out_ready)
            sat_flag <= 1'b0;
    end
`endif
endmodule
